// File: rtl/aoa_sequencer.sv
// Angle-of-arrival burst sequencer: drives TDC codes into the angle LUT,
// collects NSAMP valid angles and reports their circular mean.
module aoa_sequencer #(
    parameter int NSAMP   = 4,
    parameter int MAXTRY  = 15,
    parameter int LUT_LAT = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       code_valid,
    output logic       code_ready,
    input  logic [6:0] code_x1,
    input  logic [6:0] code_x2,
    input  logic [6:0] code_y1,
    input  logic [6:0] code_y2,
    output logic [6:0] lut_code_x1,
    output logic [6:0] lut_code_x2,
    output logic [6:0] lut_code_y1,
    output logic [6:0] lut_code_y2,
    input  logic [8:0] lut_theta,
    output logic       busy,
    output logic       result_valid,
    input  logic       result_ack,
    output logic [8:0] result_theta,
    output logic       result_err
);

    localparam int SH = $clog2(NSAMP);
    localparam int VW = 4;
    localparam int TW = 6;
    localparam int WW = $clog2(LUT_LAT + 1) + 1;

    typedef enum logic [2:0] {
        IDLE, ARM, WAIT, EVAL, DONE
    } state_t;

    state_t                state_q;
    logic signed [11:0]    acc_q, acc_d;
    logic        [8:0]     ref_q, ref_d;
    logic        [8:0]     samp_q;
    logic        [VW-1:0]  vcnt_q, vcnt_d;
    logic        [TW-1:0]  tcnt_q, tcnt_d;
    logic        [WW-1:0]  wcnt_q;
    logic                  samp_ok;
    logic signed [9:0]     diff, adj;
    logic signed [11:0]    avg, sum, wrapped;
    logic        [8:0]     theta_d;

    // Deltas are folded into -180..180 so samples straddling 0/360 average correctly
    always_comb begin
        samp_ok = (samp_q < 9'd360);
        diff    = $signed({1'b0, samp_q}) - $signed({1'b0, ref_q});
        adj     = diff;
        if (diff > 10'sd180) begin
            adj = diff - 10'sd360;
        end else if (diff < -10'sd180) begin
            adj = diff + 10'sd360;
        end
        if (vcnt_q == '0) begin
            adj = '0;
        end
        ref_d   = (vcnt_q == '0) ? samp_q : ref_q;
        acc_d   = acc_q + $signed({{2{adj[9]}}, adj});
        vcnt_d  = vcnt_q + 1'b1;
        tcnt_d  = tcnt_q + 1'b1;
        avg     = acc_d >>> SH;
        sum     = $signed({3'b000, ref_d}) + avg;
        wrapped = sum;
        if (sum < 12'sd0) begin
            wrapped = sum + 12'sd360;
        end else if (sum >= 12'sd360) begin
            wrapped = sum - 12'sd360;
        end
        theta_d = wrapped[8:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            ref_q        <= '0;
            samp_q       <= '0;
            vcnt_q       <= '0;
            tcnt_q       <= '0;
            wcnt_q       <= '0;
            code_ready   <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_err   <= 1'b0;
            result_theta <= '0;
            lut_code_x1  <= '0;
            lut_code_x2  <= '0;
            lut_code_y1  <= '0;
            lut_code_y2  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q      <= '0;
                        ref_q      <= '0;
                        vcnt_q     <= '0;
                        tcnt_q     <= '0;
                        code_ready <= 1'b1;
                        busy       <= 1'b1;
                        state_q    <= ARM;
                    end
                end
                ARM: begin
                    if (code_valid) begin
                        lut_code_x1 <= code_x1;
                        lut_code_x2 <= code_x2;
                        lut_code_y1 <= code_y1;
                        lut_code_y2 <= code_y2;
                        code_ready  <= 1'b0;
                        wcnt_q      <= WW'(1);
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (wcnt_q == WW'(LUT_LAT)) begin
                        samp_q  <= lut_theta;
                        state_q <= EVAL;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                EVAL: begin
                    tcnt_q <= tcnt_d;
                    if (samp_ok) begin
                        acc_q  <= acc_d;
                        ref_q  <= ref_d;
                        vcnt_q <= vcnt_d;
                    end
                    if (samp_ok && vcnt_d == VW'(NSAMP)) begin
                        result_valid <= 1'b1;
                        result_err   <= 1'b0;
                        result_theta <= theta_d;
                        state_q      <= DONE;
                    end else if (tcnt_d == TW'(MAXTRY)) begin
                        result_valid <= 1'b1;
                        result_err   <= 1'b1;
                        result_theta <= 9'h1FF;
                        state_q      <= DONE;
                    end else begin
                        code_ready <= 1'b1;
                        state_q    <= ARM;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aoa_sequencer.sv
// Scoreboard bench for aoa_sequencer: a one-stage LUT model feeds angles,
// expected results are queued per burst and compared on result_valid.
module tb_aoa_sequencer;

    localparam int NSAMP  = 4;
    localparam int MAXTRY = 15;
    localparam int SH     = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       code_valid = 1'b0;
    logic       code_ready;
    logic [6:0] code_x1 = '0, code_x2 = '0, code_y1 = '0, code_y2 = '0;
    logic [6:0] lut_code_x1, lut_code_x2, lut_code_y1, lut_code_y2;
    logic [8:0] lut_theta;
    logic       busy, result_valid, result_err;
    logic       result_ack = 1'b0;
    logic [8:0] result_theta;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int theta;
        int err;
        int tries;
    } exp_t;

    exp_t exp_q[$];
    int   sq[$];
    logic [8:0] tab [128];
    logic [8:0] pipe = 9'h1F0;

    always #5 clock = ~clock;

    // LUT model: one register stage, so theta is settled after two edges
    always @(posedge clock) begin
        if (lut_code_x2 == lut_code_x1 + 7'd1 &&
            lut_code_y1 == lut_code_x1 + 7'd2 &&
            lut_code_y2 == lut_code_x1 + 7'd3)
            pipe <= tab[lut_code_x1];
        else
            pipe <= 9'h1F0;
    end
    assign lut_theta = pipe;

    aoa_sequencer #(.NSAMP(NSAMP), .MAXTRY(MAXTRY), .LUT_LAT(2)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .code_valid(code_valid), .code_ready(code_ready),
        .code_x1(code_x1), .code_x2(code_x2),
        .code_y1(code_y1), .code_y2(code_y2),
        .lut_code_x1(lut_code_x1), .lut_code_x2(lut_code_x2),
        .lut_code_y1(lut_code_y1), .lut_code_y2(lut_code_y2),
        .lut_theta(lut_theta), .busy(busy),
        .result_valid(result_valid), .result_ack(result_ack),
        .result_theta(result_theta), .result_err(result_err)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        int vc = 0, acc = 0, rf = 0, d, v, r;
        e.tries = 0;
        for (int i = 0; i < MAXTRY; i++) begin
            e.tries++;
            v = (i < sq.size()) ? sq[i] : 511;
            if (v < 360) begin
                if (vc == 0) begin
                    rf = v;
                    d = 0;
                end else begin
                    d = v - rf;
                    if (d > 180) d -= 360;
                    if (d < -180) d += 360;
                end
                acc += d;
                vc++;
                if (vc == NSAMP) break;
            end
        end
        e.err = (vc != NSAMP) ? 1 : 0;
        r = rf + (acc >>> SH);
        e.theta = e.err ? 511 : (((r % 360) + 360) % 360);
        return e;
    endfunction

    task automatic burst(input int ack_delay, input bit poke, input bit ack_start);
        exp_t e;
        int hs = 0;
        int cyc = 0;
        logic [8:0] held;
        exp_q.push_back(model());
        @(negedge clock);
        check("busy_idle", busy, 0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy_start", busy, 1);
        while (!result_valid && cyc < 600) begin
            if (code_ready) begin
                tab[hs + 1] = (hs < sq.size()) ? 9'(sq[hs]) : 9'h1FF;
                code_x1 = 7'(hs + 1);
                code_x2 = 7'(hs + 2);
                code_y1 = 7'(hs + 3);
                code_y2 = 7'(hs + 4);
                code_valid = 1'b1;
                @(negedge clock);
                code_valid = 1'b0;
                hs++;
                if (poke) begin
                    start = 1'b1;
                    @(negedge clock);
                    start = 1'b0;
                end
            end else begin
                @(negedge clock);
            end
            cyc++;
        end
        check("done_timeout", result_valid, 1);
        e = exp_q.pop_front();
        check("theta", result_theta, e.theta);
        check("err", result_err, e.err);
        check("tries", hs, e.tries);
        held = result_theta;
        for (int i = 0; i < ack_delay; i++) begin
            if (i == 2) start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            check("hold_valid", result_valid, 1);
            check("hold_theta", result_theta, held);
            check("hold_ready", code_ready, 0);
        end
        result_ack = 1'b1;
        if (ack_start) start = 1'b1;
        @(negedge clock);
        result_ack = 1'b0;
        start = 1'b0;
        check("ack_valid", result_valid, 0);
        check("ack_busy", busy, 0);
        @(negedge clock);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) tab[i] = 9'h1F0;
        repeat (3) @(negedge clock);
        check("rst_ready", code_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_err", result_err, 0);
        check("rst_theta", result_theta, 0);
        check("rst_lut", lut_code_x1, 0);
        reset_n = 1'b1;

        sq = '{45, 45, 45, 45};
        burst(1, 0, 0);
        sq = '{358, 2, 359, 1};
        burst(1, 0, 0);
        sq = '{10, 8, 8, 8};
        burst(1, 0, 0);
        sq = '{511, 100, 102, 511, 104, 106};
        burst(1, 1, 0);
        sq = {};
        burst(3, 0, 0);
        sq = '{200, 210, 190, 205};
        burst(20, 0, 1);
        for (int t = 0; t < 4; t++) begin
            sq = {};
            for (int i = 0; i < 8; i++)
                sq.push_back(($urandom_range(0, 4) == 0) ? 400 : $urandom_range(0, 359));
            burst(1, 0, 0);
        end

        // reset while waiting on the LUT
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        tab[9] = 9'd77;
        code_x1 = 7'd9; code_x2 = 7'd10; code_y1 = 7'd11; code_y2 = 7'd12;
        code_valid = 1'b1;
        @(negedge clock);
        code_valid = 1'b0;
        check("wait_lut", lut_code_x1, 9);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ready", code_ready, 0);
        check("arst_lut", lut_code_x1, 0);
        check("arst_valid", result_valid, 0);
        @(negedge clock);
        reset_n = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("first_start", busy, 1);
        check("first_ready", code_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
